// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port arbiter in front of an asynchronous 8-bit SRAM
//
// Purpose:
//   Port A (core) and port B (loader/DMA) share one SRAM. Arbitration happens in
//   IDLE only. A granted transfer spends WAIT cycles in ACCESS and one cycle in
//   DONE, where the granted port's ack pulses. Every SRAM-facing output and
//   every port output is a flop.
//
// Optional feature:
//   SRAM_ARB_STARVE_EN - when defined, B wins a tie after A has been granted
//   STARVE_MAX times while b_req was high. When undefined, A has strict
//   priority and no starvation counter exists.
//
// Parameters:
//   WAIT        SRAM access cycles per transfer (1..15)
//   STARVE_MAX  tie losses before B wins a tie (1..255)
//
// Ports:
//   clk_sys, reset_n                    clock, synchronous active-low reset
//   a_req/a_we/a_addr/a_wdata           port A request, direction, address, write data
//   a_rdata/a_ack                       port A read data, one-cycle completion pulse
//   b_req/b_we/b_addr/b_wdata           port B request, direction, address, write data
//   b_rdata/b_ack                       port B read data, one-cycle completion pulse
//   sram_a, sram_dq_o, sram_dq_oe       SRAM address, write data, pad drive enable
//   sram_dq_i                           SRAM read data from the pad
//   sram_we_n, sram_oe_n                SRAM write enable and output enable (active-low)
//   busy                                high whenever the FSM is not in IDLE
module sram_arbiter #(
  parameter int WAIT       = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [20:0] a_addr,
  input  logic [7:0]  a_wdata,
  output logic [7:0]  a_rdata,
  output logic        a_ack,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [20:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic [7:0]  b_rdata,
  output logic        b_ack,
  output logic [20:0] sram_a,
  output logic [7:0]  sram_dq_o,
  output logic        sram_dq_oe,
  input  logic [7:0]  sram_dq_i,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        busy
);

  if (WAIT < 1 || WAIT > 15) begin : g_bad_wait
    $error("sram_arbiter: WAIT out of range 1..15");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve
    $error("sram_arbiter: STARVE_MAX out of range 1..255");
  end

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_b_q, gnt_b_d;
  logic        we_q, we_d;
  logic [20:0] sram_a_q, sram_a_d;
  logic [7:0]  sram_dq_o_q, sram_dq_o_d;
  logic        sram_dq_oe_q, sram_dq_oe_d;
  logic        sram_we_n_q, sram_we_n_d;
  logic        sram_oe_n_q, sram_oe_n_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic [7:0]  a_rdata_q, a_rdata_d;
  logic [7:0]  b_rdata_q, b_rdata_d;
  logic        busy_q, busy_d;

  // grant_b only matters in IDLE with at least one request pending.
  logic        grant_b;
  logic        sel_we;
  logic [20:0] sel_addr;
  logic [7:0]  sel_wdata;

`ifdef SRAM_ARB_STARVE_EN
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
  logic [7:0] starve_q, starve_d;

  assign grant_b = b_req & (~a_req | (starve_q == STARVE_LIM));

  // Counts A grants that B lost; saturates so B keeps winning ties once due.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE && (a_req || b_req)) begin
      if (grant_b) begin
        starve_d = 8'd0;
      end else if (b_req && starve_q != STARVE_LIM) begin
        starve_d = starve_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      starve_q <= 8'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign grant_b = b_req & ~a_req;
`endif

  assign sel_we    = grant_b ? b_we    : a_we;
  assign sel_addr  = grant_b ? b_addr  : a_addr;
  assign sel_wdata = grant_b ? b_wdata : a_wdata;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gnt_b_d      = gnt_b_q;
    we_d         = we_q;
    sram_a_d     = sram_a_q;
    sram_dq_o_d  = sram_dq_o_q;
    sram_dq_oe_d = sram_dq_oe_q;
    sram_we_n_d  = sram_we_n_q;
    sram_oe_n_d  = sram_oe_n_q;
    a_ack_d      = 1'b0;
    b_ack_d      = 1'b0;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;

    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          // sram_a_q / sram_dq_o_q double as the latched address and write data,
          // so later changes on the port inputs cannot disturb the access.
          state_d      = ACCESS;
          cnt_d        = WAIT_CNT;
          gnt_b_d      = grant_b;
          we_d         = sel_we;
          sram_a_d     = sel_addr;
          sram_we_n_d  = ~sel_we;
          sram_oe_n_d  = sel_we;
          sram_dq_oe_d = sel_we;
          if (sel_we) begin
            sram_dq_o_d = sel_wdata;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          // Strobes rise entering DONE; a write keeps driving data one more cycle.
          state_d     = DONE;
          sram_we_n_d = 1'b1;
          sram_oe_n_d = 1'b1;
          if (gnt_b_q) begin
            b_ack_d = 1'b1;
          end else begin
            a_ack_d = 1'b1;
          end
          if (!we_q) begin
            if (gnt_b_q) begin
              b_rdata_d = sram_dq_i;
            end else begin
              a_rdata_d = sram_dq_i;
            end
          end
        end
      end
      DONE: begin
        state_d      = IDLE;
        sram_dq_oe_d = 1'b0;
      end
      default: begin
        state_d      = IDLE;
        sram_we_n_d  = 1'b1;
        sram_oe_n_d  = 1'b1;
        sram_dq_oe_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      gnt_b_q      <= 1'b0;
      we_q         <= 1'b0;
      sram_a_q     <= 21'd0;
      sram_dq_o_q  <= 8'd0;
      sram_dq_oe_q <= 1'b0;
      sram_we_n_q  <= 1'b1;
      sram_oe_n_q  <= 1'b1;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      a_rdata_q    <= 8'd0;
      b_rdata_q    <= 8'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gnt_b_q      <= gnt_b_d;
      we_q         <= we_d;
      sram_a_q     <= sram_a_d;
      sram_dq_o_q  <= sram_dq_o_d;
      sram_dq_oe_q <= sram_dq_oe_d;
      sram_we_n_q  <= sram_we_n_d;
      sram_oe_n_q  <= sram_oe_n_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign sram_a     = sram_a_q;
  assign sram_dq_o  = sram_dq_o_q;
  assign sram_dq_oe = sram_dq_oe_q;
  assign sram_we_n  = sram_we_n_q;
  assign sram_oe_n  = sram_oe_n_q;
  assign a_ack      = a_ack_q;
  assign b_ack      = b_ack_q;
  assign a_rdata    = a_rdata_q;
  assign b_rdata    = b_rdata_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        a_req, a_we, b_req, b_we;
  logic [20:0] a_addr, b_addr;
  logic [7:0]  a_wdata, b_wdata, sram_dq_i;
  logic [7:0]  a_rdata, b_rdata, sram_dq_o;
  logic        a_ack, b_ack, sram_dq_oe, sram_we_n, sram_oe_n, busy;
  logic [20:0] sram_a;

  int tests  = 0;
  int failed = 0;

  sram_arbiter #(.WAIT(2), .STARVE_MAX(3)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_ack(b_ack),
    .sram_a(sram_a), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled on the falling edge, then strobe exclusivity checked.
  task automatic step();
    @(posedge clk_sys);
    @(negedge clk_sys);
    tests++;
    assert (!(sram_we_n === 1'b0 && sram_oe_n === 1'b0) &&
            !(sram_dq_oe === 1'b1 && sram_oe_n === 1'b0)) else begin
      failed++;
      $error("FAIL strobe_overlap: observed we_n=%b oe_n=%b dq_oe=%b expected no overlap",
             sram_we_n, sram_oe_n, sram_dq_oe);
    end
  endtask

  int          a_cyc, b_cyc, n;
  logic [20:0] a_mid;
  logic [7:0]  order, exp_order;
  int          acks [4];

  // ctrl vector = {we_n, oe_n, dq_oe, a_ack, b_ack, busy}
  initial begin
    reset_n = 1'b0; a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; sram_dq_i = '0;
    step(); step(); step();
    chk("rst_ctrl",  {sram_we_n, sram_oe_n, sram_dq_oe, a_ack, b_ack, busy}, 6'b110000);
    chk("rst_addr",  sram_a, 21'd0);
    chk("rst_dqo",   sram_dq_o, 8'd0);
    chk("rst_rdata", {a_rdata, b_rdata}, 16'd0);
    reset_n = 1'b1;
    step();

    // A read of 0x12345, pad returns 0xA5; address changed after grant
    a_req = 1'b1; a_we = 1'b0; a_addr = 21'h12345; sram_dq_i = 8'hA5;
    step();
    chk("rd_c1_ctrl", {sram_we_n, sram_oe_n, sram_dq_oe, a_ack, b_ack, busy}, 6'b100001);
    chk("rd_c1_addr", sram_a, 21'h12345);
    a_addr = 21'h0;
    step();
    chk("rd_c2_ctrl", {sram_we_n, sram_oe_n, sram_dq_oe, a_ack, b_ack, busy}, 6'b100001);
    chk("rd_c2_addr", sram_a, 21'h12345);
    step();
    chk("rd_c3_ctrl", {sram_we_n, sram_oe_n, sram_dq_oe, a_ack, b_ack, busy}, 6'b110101);
    chk("rd_c3_rdata", a_rdata, 8'hA5);
    a_req = 1'b0; sram_dq_i = 8'h00;
    step();
    chk("rd_c4_ctrl", {sram_we_n, sram_oe_n, sram_dq_oe, a_ack, b_ack, busy}, 6'b110000);
    chk("rd_c4_hold", a_rdata, 8'hA5);
    chk("rd_c4_addr", sram_a, 21'h12345);

    // B write of 0x5A to 0x00010; wdata and we changed after grant
    b_req = 1'b1; b_we = 1'b1; b_addr = 21'h00010; b_wdata = 8'h5A;
    step();
    chk("wr_c1_ctrl", {sram_we_n, sram_oe_n, sram_dq_oe, a_ack, b_ack, busy}, 6'b011001);
    chk("wr_c1_addr", sram_a, 21'h00010);
    chk("wr_c1_dq", sram_dq_o, 8'h5A);
    b_wdata = 8'hFF; b_we = 1'b0;
    step();
    chk("wr_c2_ctrl", {sram_we_n, sram_oe_n, sram_dq_oe, a_ack, b_ack, busy}, 6'b011001);
    chk("wr_c2_dq", sram_dq_o, 8'h5A);
    step();
    chk("wr_c3_ctrl", {sram_we_n, sram_oe_n, sram_dq_oe, a_ack, b_ack, busy}, 6'b111011);
    chk("wr_c3_dq", sram_dq_o, 8'h5A);
    chk("wr_c3_brdata", b_rdata, 8'h00);
    b_req = 1'b0;
    step();
    chk("wr_c4_ctrl", {sram_we_n, sram_oe_n, sram_dq_oe, a_ack, b_ack, busy}, 6'b110000);

    // Simultaneous requests: A first, B acked WAIT+2 cycles later
    a_req = 1'b1; a_we = 1'b0; a_addr = 21'h00001;
    b_req = 1'b1; b_we = 1'b0; b_addr = 21'h00002; sram_dq_i = 8'h3C;
    a_cyc = 0; b_cyc = 0; a_mid = '0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      step();
      if (cyc == 5) a_mid = sram_a;
      if (a_ack) begin a_cyc = cyc; a_req = 1'b0; sram_dq_i = 8'h77; end
      if (b_ack) begin b_cyc = cyc; b_req = 1'b0; end
    end
    chk("tie_a_ack_cyc", a_cyc, 3);
    chk("tie_b_ack_cyc", b_cyc, 7);
    chk("tie_b_addr", a_mid, 21'h00002);
    chk("tie_a_rdata", a_rdata, 8'h3C);
    chk("tie_b_rdata", b_rdata, 8'h77);

    // Both requests held continuously: grant order over eight transfers
    reset_n = 1'b0; step(); reset_n = 1'b1;
    a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0;
    order = '0; n = 0;
    for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
      step();
      if (a_ack || b_ack) begin order[n] = b_ack; n++; end
    end
`ifdef SRAM_ARB_STARVE_EN
    exp_order = 8'b1000_1000;
`else
    exp_order = 8'b0000_0000;
`endif
    chk("order_count", n, 8);
    chk("order_seq", order, exp_order);
    a_req = 1'b0; b_req = 1'b0;
    step(); step();
    chk("order_idle", busy, 1'b0);

    // Back-to-back A reads with a_req held
    a_req = 1'b1; a_we = 1'b0; n = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      step();
      if (a_ack && n < 4) begin acks[n] = cyc; n++; end
    end
    a_req = 1'b0;
    chk("b2b_count", n, 4);
    chk("b2b_first", acks[0], 3);
    chk("b2b_gap1", acks[1] - acks[0], 4);
    chk("b2b_gap2", acks[2] - acks[1], 4);
    chk("b2b_gap3", acks[3] - acks[2], 4);
    step(); step(); step();

    // Reset during the second ACCESS cycle of a write
    a_req = 1'b1; a_we = 1'b1; a_addr = 21'h1ABCD; a_wdata = 8'hC3;
    step();
    chk("abort_c1_ctrl", {sram_we_n, sram_oe_n, sram_dq_oe, a_ack, b_ack, busy}, 6'b011001);
    step();
    reset_n = 1'b0; a_req = 1'b0;
    step();
    chk("abort_ctrl", {sram_we_n, sram_oe_n, sram_dq_oe, a_ack, b_ack, busy}, 6'b110000);
    chk("abort_addr", sram_a, 21'd0);
    chk("abort_rdata", a_rdata, 8'd0);
    reset_n = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      step();
      if (a_ack || b_ack) n++;
    end
    chk("abort_no_ack", n, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter WAIT, default 2: SRAM access cycles per transfer; legal range 1..15.
REQ-002 Parameter STARVE_MAX, default 8: consecutive lost arbitrations after which port B wins a tie; legal range 1..255.
REQ-003 clk_sys  in  1  single clock; all logic rising-edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 a_req  in  1  port A (core) request; level, held until a_ack.
REQ-006 a_we  in  1  port A write when 1, read when 0.
REQ-007 a_addr  in  21  port A byte address.
REQ-008 a_wdata  in  8  port A write data.
REQ-009 a_rdata  out  8  port A read data.
REQ-010 a_ack  out  1  port A one-cycle completion pulse.
REQ-011 b_req, b_we, b_addr[20:0], b_wdata[7:0], b_rdata[7:0], b_ack: same directions, widths and meanings for port B (loader/DMA).
REQ-012 sram_a  out  21  SRAM address.
REQ-013 sram_dq_o  out  8  SRAM write data.
REQ-014 sram_dq_oe  out  1  drive sram_dq_o onto the pad when 1.
REQ-015 sram_dq_i  in  8  SRAM read data from the pad.
REQ-016 sram_we_n  out  1  SRAM write enable, active-low.
REQ-017 sram_oe_n  out  1  SRAM output enable, active-low.
REQ-018 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
REQ-020 IDLE: if any req is high, grant one port, latch its we/addr/wdata into internal registers, load the wait counter with WAIT and go to ACCESS; otherwise stay in IDLE.
REQ-021 Arbitration: A wins when both req are high, except where REQ-035 applies; arbitration SHALL occur only in IDLE.
REQ-022 ACCESS: decrement the counter each cycle; on the cycle the counter equals 1, go to DONE; ACCESS therefore lasts exactly WAIT cycles.
REQ-023 sram_a SHALL equal the latched address throughout ACCESS and DONE, and hold its last value otherwise.
REQ-024 Read: sram_oe_n low during ACCESS only; sram_dq_i is registered into the granted port's rdata on the last ACCESS cycle.
REQ-025 Write: sram_dq_oe high and sram_dq_o equal to the latched wdata during ACCESS and DONE; sram_we_n low during ACCESS only, so data is held one cycle past the rising edge of we_n.
REQ-026 sram_we_n and sram_oe_n SHALL never be low in the same cycle; sram_dq_oe SHALL never be high during a read.
REQ-027 DONE: pulse the granted port's ack for one cycle, then go to IDLE.
REQ-028 Read data SHALL be valid in the ack cycle and held until that port's next read completes.
REQ-029 Latency: from req sampled in IDLE at cycle 0, ack occurs at cycle WAIT+1; sustained throughput is one access per WAIT+2 cycles.
REQ-030 A req still high in the DONE cycle SHALL be treated as a new request in the following IDLE cycle.
REQ-031 The non-granted port's req and inputs SHALL be ignored until IDLE.
REQ-032 A requester changing addr/we/wdata after grant SHALL not affect the access in flight.

Reset
REQ-033 While reset_n is low at a clock edge: state becomes IDLE; sram_we_n=1, sram_oe_n=1, sram_dq_oe=0; a_ack=b_ack=0; a_rdata=b_rdata=0; sram_a=0; sram_dq_o=0; counters=0; busy=0.
REQ-034 Reset asserted mid-access SHALL abort the access with no ack, and SHALL take effect at that edge regardless of state.

Configuration
REQ-035 With SRAM_ARB_STARVE_EN defined: a starvation counter increments each time A is granted while b_req is high, saturating at STARVE_MAX, and clears on any B grant; when it equals STARVE_MAX and both req are high in IDLE, B is granted.
REQ-036 Without SRAM_ARB_STARVE_EN: strict A priority, and no starvation counter is synthesised.

Verification
REQ-037 WAIT=2, A read of 0x12345 with sram_dq_i=0xA5 -> oe_n low for 2 cycles, a_ack at cycle 3, a_rdata=0xA5.
REQ-038 WAIT=2, B write of 0x5A to 0x00010 -> we_n low for 2 cycles, dq_oe high for 3 cycles, b_ack at cycle 3, oe_n stays high.
REQ-039 a_req and b_req rise in the same cycle -> A is served first; B is acked WAIT+2 cycles after a_ack.
REQ-040 Macro on, STARVE_MAX=3, both req held continuously -> grant order A,A,A,B,A,A,A,B; macro off -> B is never granted.
REQ-041 reset_n low during the second ACCESS cycle of a write -> next edge gives we_n=1, dq_oe=0, busy=0, and no ack is ever issued for that access.
REQ-042 Back-to-back A reads with a_req held high -> one a_ack every WAIT+2 cycles, with no we_n/oe_n overlap in any cycle.
